wb_stage_pipe: RTL and testbench

//  Registered, parametrised writeback stage. Accepts one retiring instruction per cycle from MEM
//  and selects the writeback source (ALU / load data / link address). Load data is byte/half

---
 rtl/wb_stage_pipe.sv | 185 ++++++++++++++++++
 tb/tb_wb_stage_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects ALU / load / link data, extracts loads and drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
   parameter int XLEN    = 32,
   parameter int RA_W    = 5,
   parameter int PC_WORD = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] ALU_result_W,
   input  logic [XLEN-1:0] PC_W,
   input  logic [1:0]      wb_ctrl_W,
   input  logic [2:0]      funct3_W,
   input  logic [RA_W-1:0] rd_W,
   input  logic            reg_write_W,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_we,
   output logic [RA_W-1:0] rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_busy
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [63:0]     retire_cnt
`endif
);

   localparam logic [0:0]      S_IDLE     = 1'b0;
   localparam logic [0:0]      S_WAIT_MEM = 1'b1;
   localparam logic [XLEN-1:0] LINK_INC   = {{(XLEN-3){1'b0}}, 3'b100};

   logic [0:0]      state_q, state_d;
   logic            rf_we_q, rf_we_d;
   logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic [RA_W-1:0] pend_rd_q, pend_rd_d;
   logic            pend_we_q, pend_we_d;
   logic [2:0]      pend_f3_q, pend_f3_d;
   logic [2:0]      pend_off_q, pend_off_d;
   logic            complete_s;
   logic [2:0]      in_off_s;
   logic [XLEN-1:0] link_s;
   logic [XLEN-1:0] sel_s;

   // Offsets are byte positions inside the aligned word; a 32-bit datapath has only four.
   function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                    input logic [2:0]      off,
                                                    input logic [XLEN-1:0] raw);
      logic [XLEN-1:0] byte_sh;
      logic [XLEN-1:0] half_sh;
      logic [XLEN-1:0] word_sh;
      logic [XLEN-1:0] ext;
      byte_sh = raw >> {off, 3'b000};
      half_sh = raw >> {off[2:1], 4'b0000};
      word_sh = raw >> {off[2], 5'b00000};
      ext     = raw;
      case (f3)
         3'b000: begin ext = {XLEN{byte_sh[7]}};  ext[7:0]  = byte_sh[7:0];  end
         3'b100: begin ext = {XLEN{1'b0}};        ext[7:0]  = byte_sh[7:0];  end
         3'b001: begin ext = {XLEN{half_sh[15]}}; ext[15:0] = half_sh[15:0]; end
         3'b101: begin ext = {XLEN{1'b0}};        ext[15:0] = half_sh[15:0]; end
         3'b010: begin ext = {XLEN{word_sh[31]}}; ext[31:0] = word_sh[31:0]; end
         3'b110: begin
            if (XLEN == 64) begin
               ext = {XLEN{1'b0}};
               ext[31:0] = word_sh[31:0];
            end else begin
               ext = raw;
            end
         end
         default: ext = raw;
      endcase
      return ext;
   endfunction

   assign in_off_s = (XLEN == 64) ? ALU_result_W[2:0] : {1'b0, ALU_result_W[1:0]};
   assign link_s   = (PC_WORD != 0) ? ({PC_W[XLEN-3:0], 2'b00} + LINK_INC) : (PC_W + LINK_INC);

   // Writeback source mux for an instruction completing straight from IDLE.
   always_comb begin
      sel_s = ALU_result_W;
      case (wb_ctrl_W)
         2'b01:   sel_s = load_extract(funct3_W, in_off_s, mem_rdata);
         2'b11:   sel_s = link_s;
         default: sel_s = ALU_result_W;
      endcase
   end

   // Next-state: accept, park a late load, or complete a parked load.
   always_comb begin
      state_d    = state_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      pend_rd_d  = pend_rd_q;
      pend_we_d  = pend_we_q;
      pend_f3_d  = pend_f3_q;
      pend_off_d = pend_off_q;
      complete_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if ((wb_ctrl_W == 2'b01) && !mem_rvalid) begin
                  state_d    = S_WAIT_MEM;
                  pend_rd_d  = rd_W;
                  pend_we_d  = reg_write_W && (rd_W != {RA_W{1'b0}});
                  pend_f3_d  = funct3_W;
                  pend_off_d = in_off_s;
               end else begin
                  rf_we_d    = reg_write_W && (rd_W != {RA_W{1'b0}});
                  rf_waddr_d = rd_W;
                  rf_wdata_d = sel_s;
                  complete_s = 1'b1;
               end
            end else begin
               rf_we_d = 1'b0;
            end
         end
         S_WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d    = S_IDLE;
               rf_we_d    = pend_we_q;
               rf_waddr_d = pend_rd_q;
               rf_wdata_d = load_extract(pend_f3_q, pend_off_q, mem_rdata);
               complete_s = 1'b1;
            end else begin
               state_d = S_WAIT_MEM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= {RA_W{1'b0}};
         rf_wdata_q <= {XLEN{1'b0}};
         pend_rd_q  <= {RA_W{1'b0}};
         pend_we_q  <= 1'b0;
         pend_f3_q  <= 3'b000;
         pend_off_q <= 3'b000;
      end else begin
         state_q    <= state_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pend_rd_q  <= pend_rd_d;
         pend_we_q  <= pend_we_d;
         pend_f3_q  <= pend_f3_d;
         pend_off_q <= pend_off_d;
      end
   end

   assign in_ready = (state_q == S_IDLE);
   assign wb_busy  = (state_q == S_WAIT_MEM);
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_q;

   // Counts every completed writeback, including those to x0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_q <= 64'd0;
      end else if (complete_s) begin
         retire_q <= retire_q + 64'd1;
      end else begin
         retire_q <= retire_q;
      end
   end

   assign retire_cnt = retire_q;
`else
   logic unused_complete_s;
   assign unused_complete_s = complete_s;
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: vector table, hand-written multi-cycle sequences and a randomized run
// against a behavioural model. Two instances cover both PC encodings.
module tb_wb_stage_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] alu, pc, rdata;
   logic [1:0]  ctrl;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic        rw, rv;
   logic        rdy1, busy1, we1, rdy0, busy0, we0;
   logic [4:0]  wa1, wa0;
   logic [31:0] wd1, wd0;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] cnt1, cnt0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_stage_pipe #(.XLEN(32), .RA_W(5), .PC_WORD(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .ALU_result_W(alu), .PC_W(pc), .wb_ctrl_W(ctrl), .funct3_W(f3), .rd_W(rd),
      .reg_write_W(rw), .mem_rvalid(rv), .mem_rdata(rdata),
      .rf_we(we1), .rf_waddr(wa1), .rf_wdata(wd1), .wb_busy(busy1)
`ifdef WB_RETIRE_CNT_EN
      , .retire_cnt(cnt1)
`endif
   );

   wb_stage_pipe #(.XLEN(32), .RA_W(5), .PC_WORD(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .ALU_result_W(alu), .PC_W(pc), .wb_ctrl_W(ctrl), .funct3_W(f3), .rd_W(rd),
      .reg_write_W(rw), .mem_rvalid(rv), .mem_rdata(rdata),
      .rf_we(we0), .rf_waddr(wa0), .rf_wdata(wd0), .wb_busy(busy0)
`ifdef WB_RETIRE_CNT_EN
      , .retire_cnt(cnt0)
`endif
   );

   typedef struct {
      logic v; logic [1:0] c; logic [2:0] f3; logic [31:0] alu; logic [31:0] pc;
      logic [4:0] rd; logic rw; logic rv; logic [31:0] rdata;
      logic ewe; logic [4:0] ewa; logic [31:0] ewd;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] c, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] p, input logic [4:0] r, input logic w, input logic mv,
                        input logic [31:0] md);
      in_valid = v; ctrl = c; f3 = f; alu = a; pc = p; rd = r; rw = w; rv = mv; rdata = md;
   endtask

   // Reference load extraction from byte arithmetic on a 32-bit word.
   function automatic logic [31:0] ref_load(input logic [2:0] fn, input int off, input logic [31:0] raw);
      longint w;
      longint s;
      int hoff;
      w = longint'(raw);
      hoff = off - (off % 2);
      case (fn)
         3'd0: begin s = (w >> (8 * off)) % 256;    if (s >= 128)   s = s - 256;   end
         3'd4: s = (w >> (8 * off)) % 256;
         3'd1: begin s = (w >> (8 * hoff)) % 65536; if (s >= 32768) s = s - 65536; end
         3'd5: s = (w >> (8 * hoff)) % 65536;
         default: s = w;
      endcase
      return s[31:0];
   endfunction

   function automatic logic [31:0] ref_val(input logic [1:0] c, input logic [2:0] fn, input logic [31:0] a,
                                           input logic [31:0] p, input logic [31:0] md, input bit pcword);
      longint t;
      if (c == 2'b01) return ref_load(fn, int'(a % 4), md);
      if (c == 2'b11) begin
         t = pcword ? (longint'(p) * 4 + 4) : (longint'(p) + 4);
         return t[31:0];
      end
      return a;
   endfunction

   bit          m_wait;
   logic [4:0]  m_rd;
   logic        m_rw;
   logic [2:0]  m_f3;
   int          m_off;
   logic        e_we;
   logic [4:0]  e_wa;
   logic [31:0] e_wd, e_wd0;
   longint      e_cnt;

   initial begin
      tbl[0]  = '{1'b1, 2'b00, 3'd0, 32'h1234_5678, 32'h0, 5'd5,  1'b1, 1'b0, 32'h0,         1'b1, 5'd5,  32'h1234_5678};
      tbl[1]  = '{1'b1, 2'b11, 3'd0, 32'h0,         32'h10, 5'd1, 1'b1, 1'b0, 32'h0,         1'b1, 5'd1,  32'h0000_0044};
      tbl[2]  = '{1'b1, 2'b01, 3'd0, 32'h3,         32'h0, 5'd2,  1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd2,  32'hFFFF_FF80};
      tbl[3]  = '{1'b1, 2'b01, 3'd5, 32'h2,         32'h0, 5'd3,  1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd3,  32'h0000_80FF};
      tbl[4]  = '{1'b1, 2'b01, 3'd1, 32'h3,         32'h0, 5'd4,  1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd4,  32'hFFFF_80FF};
      tbl[5]  = '{1'b1, 2'b01, 3'd4, 32'h1,         32'h0, 5'd6,  1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd6,  32'h0000_007F};
      tbl[6]  = '{1'b1, 2'b01, 3'd0, 32'h0,         32'h0, 5'd8,  1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd8,  32'h0000_0001};
      tbl[7]  = '{1'b1, 2'b01, 3'd1, 32'h0,         32'h0, 5'd11, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd11, 32'h0000_7F01};
      tbl[8]  = '{1'b1, 2'b01, 3'd2, 32'h2,         32'h0, 5'd15, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd15, 32'h80FF_7F01};
      tbl[9]  = '{1'b1, 2'b10, 3'd0, 32'hDEAD_BEEF, 32'h0, 5'd7,  1'b1, 1'b0, 32'h0,         1'b1, 5'd7,  32'hDEAD_BEEF};
      tbl[10] = '{1'b1, 2'b00, 3'd0, 32'h0000_AAAA, 32'h0, 5'd0,  1'b1, 1'b0, 32'h0,         1'b0, 5'd0,  32'h0000_AAAA};
      tbl[11] = '{1'b1, 2'b00, 3'd0, 32'h5,         32'h0, 5'd9,  1'b0, 1'b0, 32'h0,         1'b0, 5'd9,  32'h0000_0005};
      tbl[12] = '{1'b1, 2'b01, 3'd3, 32'h1,         32'h0, 5'd10, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1, 5'd10, 32'h80FF_7F01};
      tbl[13] = '{1'b0, 2'b00, 3'd0, 32'h777,       32'h0, 5'd20, 1'b1, 1'b0, 32'h0,         1'b0, 5'd10, 32'h80FF_7F01};
      tbl[14] = '{1'b1, 2'b01, 3'd7, 32'h0,         32'h0, 5'd31, 1'b1, 1'b1, 32'h0123_4567, 1'b1, 5'd31, 32'h0123_4567};
      tbl[15] = '{1'b0, 2'b01, 3'd0, 32'h0,         32'h0, 5'd12, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd31, 32'h0123_4567};

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      step(); step();
      chk("reset_we", 64'(we1), 64'd0);
      chk("reset_waddr", 64'(wa1), 64'd0);
      chk("reset_wdata", 64'(wd1), 64'd0);
      chk("reset_busy", 64'(busy1), 64'd0);
      chk("reset_ready", 64'(rdy1), 64'd1);
      rst_n = 1'b1;
      step();

      // Single-cycle vectors
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].f3, tbl[i].alu, tbl[i].pc, tbl[i].rd, tbl[i].rw, tbl[i].rv, tbl[i].rdata);
         #1;
         chk($sformatf("tbl%0d_ready", i), 64'(rdy1), 64'd1);
         step();
         chk($sformatf("tbl%0d_we", i), 64'(we1), 64'(tbl[i].ewe));
         chk($sformatf("tbl%0d_waddr", i), 64'(wa1), 64'(tbl[i].ewa));
         chk($sformatf("tbl%0d_wdata", i), 64'(wd1), 64'(tbl[i].ewd));
         if (tbl[i].c != 2'b11) chk($sformatf("tbl%0d_wdata_pcbyte", i), 64'(wd0), 64'(tbl[i].ewd));
      end

      // Link wrap for both PC encodings
      drive(1'b1, 2'b11, 3'd0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 1'b0, 32'h0);
      step();
      chk("link_wrap_byte", 64'(wd0), 64'h0);
      chk("link_word_fffffffc", 64'(wd1), 64'hFFFF_FFF4);
      drive(1'b1, 2'b11, 3'd0, 32'h0, 32'h3FFF_FFFF, 5'd1, 1'b1, 1'b0, 32'h0);
      step();
      chk("link_wrap_word", 64'(wd1), 64'h0);

      // Late load: three idle cycles then data; other instructions offered meanwhile must not be taken
      drive(1'b1, 2'b01, 3'd0, 32'h3, 32'h0, 5'd12, 1'b1, 1'b0, 32'h0);
      step();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 2'b00, 3'd5, 32'h0000_0102, 32'h0, 5'd13, 1'b1, (k == 3), 32'h80FF_7F01);
         #1;
         chk($sformatf("late%0d_busy", k), 64'(busy1), 64'd1);
         chk($sformatf("late%0d_ready", k), 64'(rdy1), 64'd0);
         chk($sformatf("late%0d_we", k), 64'(we1), 64'd0);
         step();
      end
      chk("late_done_we", 64'(we1), 64'd1);
      chk("late_done_waddr", 64'(wa1), 64'd12);
      chk("late_done_wdata", 64'(wd1), 64'hFFFF_FF80);
      chk("late_done_busy", 64'(busy1), 64'd0);
      chk("late_done_ready", 64'(rdy1), 64'd1);
      drive(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      step();
      chk("late_no_extra_we", 64'(we1), 64'd0);

      // Reset while a load is pending drops it
      drive(1'b1, 2'b01, 3'd2, 32'h0, 32'h0, 5'd14, 1'b1, 1'b0, 32'h0);
      step();
      chk("rstwait_busy", 64'(busy1), 64'd1);
      drive(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rv = 1'b1; rdata = 32'h5555_5555;
      step();
      chk("rstwait_we", 64'(we1), 64'd0);
      chk("rstwait_ready", 64'(rdy1), 64'd1);
      chk("rstwait_wdata", 64'(wd1), 64'd0);

      // Randomized run against the behavioural model
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      step();
      rst_n = 1'b1;
      m_wait = 1'b0; e_we = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_wd0 = 32'd0; e_cnt = 0;
      m_rd = 5'd0; m_rw = 1'b0; m_f3 = 3'd0; m_off = 0;
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), $urandom, $urandom,
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
               ($urandom_range(0, 2) == 0), $urandom);
         #1;
         chk("rnd_ready", 64'(rdy1), 64'(!m_wait));
         chk("rnd_busy", 64'(busy1), 64'(m_wait));
         e_we = 1'b0;
         if (!m_wait) begin
            if (in_valid) begin
               if (ctrl == 2'b01 && !rv) begin
                  m_wait = 1'b1; m_rd = rd; m_rw = rw; m_f3 = f3; m_off = int'(alu % 4);
               end else begin
                  e_we = rw && (rd != 5'd0); e_wa = rd;
                  e_wd  = ref_val(ctrl, f3, alu, pc, rdata, 1'b1);
                  e_wd0 = ref_val(ctrl, f3, alu, pc, rdata, 1'b0);
                  e_cnt++;
               end
            end
         end else if (rv) begin
            m_wait = 1'b0;
            e_we = m_rw && (m_rd != 5'd0); e_wa = m_rd;
            e_wd = ref_load(m_f3, m_off, rdata); e_wd0 = e_wd;
            e_cnt++;
         end
         step();
         chk("rnd_we", 64'(we1), 64'(e_we));
         chk("rnd_waddr", 64'(wa1), 64'(e_wa));
         chk("rnd_wdata", 64'(wd1), 64'(e_wd));
         chk("rnd_wdata_pcbyte", 64'(wd0), 64'(e_wd0));
`ifdef WB_RETIRE_CNT_EN
         chk("rnd_retire_cnt", cnt1, 64'(e_cnt));
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
